// File: rtl/skip_decode_pkg.sv
// Shared definitions for the skip-clock receive decoder: FSM encoding and the
// ring defaults also used by the generator side.
package skip_decode_pkg;

   localparam int DEF_LEN      = 16;
   localparam int DEF_LOCK_CNT = 2;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      COLLECT = 2'd1,
      CHECK   = 2'd2
   } state_t;

endpackage

// File: rtl/sync_edge.sv
// N-flop synchronizer for an asynchronous level, with single-cycle
// rise/fall pulses derived from the synchronized output.
module sync_edge #(
   parameter int N = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [N-1:0] sync_q;
   logic [N-1:0] sync_d;
   logic         last_q;
   logic         last_d;

   always_comb begin
      sync_d = {sync_q[N-2:0], d};
      last_d = sync_q[N-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         last_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         last_q <= last_d;
      end
   end

   assign q    = sync_q[N-1];
   assign rise = sync_q[N-1] & ~last_q;
   assign fall = ~sync_q[N-1] & last_q;

endmodule

// File: rtl/skip_decode.sv
// Recovers the skip mask of a gated clock ring, frames it on the bit-0 marker
// and reports lock once LOCK_CNT consecutive frames agree.
module skip_decode
   import skip_decode_pkg::*;
#(
   parameter int LEN      = DEF_LEN,
   parameter int LOCK_CNT = DEF_LOCK_CNT,
   parameter int SYNC     = 2
) (
   input  logic           mCLK,
   input  logic           nRST,
   input  logic           E,
   input  logic           iCLK,
   input  logic           iSCLK,
   input  logic           iB0,
   output logic [LEN-1:0] oMASK,
   output logic           oVALID,
   output logic           oLOCKED,
   output logic           oERR
);

   localparam int PW = $clog2(LEN + 1);
   localparam int MW = $clog2(LOCK_CNT + 1);

   logic clk_s, clk_rise, clk_fall;
   logic sclk_s, sclk_rise, sclk_fall;
   logic b0_s, b0_rise, b0_fall;

   sync_edge #(.N(SYNC)) u_sync_clk (
      .clk(mCLK), .rst_n(nRST), .d(iCLK), .q(clk_s), .rise(clk_rise), .fall(clk_fall)
   );
   sync_edge #(.N(SYNC)) u_sync_sclk (
      .clk(mCLK), .rst_n(nRST), .d(iSCLK), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
   );
   sync_edge #(.N(SYNC)) u_sync_b0 (
      .clk(mCLK), .rst_n(nRST), .d(iB0), .q(b0_s), .rise(b0_rise), .fall(b0_fall)
   );

   logic unused_edges;
   assign unused_edges = ^{clk_rise, sclk_rise, sclk_fall, b0_rise, b0_fall};

   state_t          state_q, state_d;
   logic [PW-1:0]   pos_q, pos_d;
   logic [LEN-1:0]  sh_q, sh_d;
   logic [LEN-1:0]  mask_q, mask_d;
   logic [MW-1:0]   match_q, match_d;
   logic            seen_q, seen_d;
   logic            locked_q, locked_d;
   logic            valid_q, valid_d;
   logic            err_q, err_d;

   logic slot_ev;
   logic slot_bit;
   logic mark;

   assign slot_ev  = clk_fall;
   assign slot_bit = ~seen_q;
   assign mark     = b0_s;

   always_comb begin
      state_d  = state_q;
      pos_d    = pos_q;
      sh_d     = sh_q;
      mask_d   = mask_q;
      match_d  = match_q;
      locked_d = locked_q;
      valid_d  = 1'b0;
      err_d    = 1'b0;
      seen_d   = seen_q | (clk_s & sclk_s);
      if (slot_ev) begin
         seen_d = 1'b0;
      end

      if (!E) begin
         state_d  = HUNT;
         pos_d    = '0;
         match_d  = '0;
         locked_d = 1'b0;
      end else begin
         case (state_q)
            HUNT: begin
               if (slot_ev && mark) begin
                  sh_d[0] = slot_bit;
                  pos_d   = PW'(1);
                  state_d = COLLECT;
               end
            end
            COLLECT: begin
               if (slot_ev) begin
                  if (mark) begin
                     // A marker anywhere but slot 0 restarts the frame here.
                     if (pos_q != '0) begin
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                        match_d  = '0;
                     end
                     sh_d[0] = slot_bit;
                     pos_d   = PW'(1);
                  end else if (pos_q == '0 || pos_q == PW'(LEN)) begin
                     err_d    = 1'b1;
                     locked_d = 1'b0;
                     match_d  = '0;
                     pos_d    = '0;
                     state_d  = HUNT;
                  end else begin
                     for (int i = 1; i < LEN; i++) begin
                        if (pos_q == PW'(i)) begin
                           sh_d[i] = slot_bit;
                        end
                     end
                     pos_d = pos_q + PW'(1);
                     if (pos_q == PW'(LEN - 1)) begin
                        state_d = CHECK;
                     end
                  end
               end
            end
            CHECK: begin
               mask_d  = sh_q;
               valid_d = 1'b1;
               if (sh_q == mask_q) begin
                  if (match_q != MW'(LOCK_CNT)) begin
                     match_d = match_q + MW'(1);
                  end
                  if (match_d == MW'(LOCK_CNT)) begin
                     locked_d = 1'b1;
                  end
               end else begin
                  match_d  = MW'(1);
                  locked_d = 1'b0;
                  err_d    = locked_q;
                  if (LOCK_CNT == 1 && !locked_q) begin
                     locked_d = 1'b1;
                  end
               end
               pos_d   = '0;
               state_d = COLLECT;
            end
            default: begin
               state_d = HUNT;
               pos_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge mCLK or negedge nRST) begin
      if (!nRST) begin
         state_q  <= HUNT;
         pos_q    <= '0;
         sh_q     <= '0;
         mask_q   <= '0;
         match_q  <= '0;
         seen_q   <= 1'b0;
         locked_q <= 1'b0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pos_q    <= pos_d;
         sh_q     <= sh_d;
         mask_q   <= mask_d;
         match_q  <= match_d;
         seen_q   <= seen_d;
         locked_q <= locked_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
      end
   end

   assign oMASK   = mask_q;
   assign oVALID  = valid_q;
   assign oLOCKED = locked_q;
   assign oERR    = err_q;

endmodule

// File: tb/tb_skip_decode.sv
// Directed bench: a behavioural skip ring drives the decoder slot by slot.
module tb_skip_decode;

   logic        mCLK = 1'b0;
   logic        nRST = 1'b0;
   logic        E = 1'b1;
   logic        iCLK = 1'b0;
   logic        iSCLK = 1'b0;
   logic        iB0 = 1'b0;
   logic [15:0] oMASK;
   logic        oVALID;
   logic        oLOCKED;
   logic        oERR;

   int n_cmp = 0;
   int n_bad = 0;
   int valid_cnt = 0;
   int err_cnt = 0;
   int both_cnt = 0;
   int v0, e0, b0;

   skip_decode #(.LEN(16), .LOCK_CNT(2), .SYNC(2)) dut (
      .mCLK(mCLK), .nRST(nRST), .E(E), .iCLK(iCLK), .iSCLK(iSCLK), .iB0(iB0),
      .oMASK(oMASK), .oVALID(oVALID), .oLOCKED(oLOCKED), .oERR(oERR)
   );

   always #5 mCLK = ~mCLK;

   always @(negedge mCLK) begin
      if (oVALID) valid_cnt++;
      if (oERR) err_cnt++;
      if (oVALID && oERR) both_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   // One ring slot of 64 mCLK: iCLK high for the first half, iSCLK follows
   // iCLK delayed by skew unless the slot is skipped.
   task automatic send_slot(input logic skip, input logic mark, input int skew);
      for (int c = 0; c < 64; c++) begin
         if (c == 0) begin
            iCLK = 1'b1;
            iB0  = mark;
         end
         if (c == skew) iSCLK = ~skip;
         if (c == 32) iCLK = 1'b0;
         if (c == 32 + skew) iSCLK = 1'b0;
         @(posedge mCLK);
         #3;
      end
   endtask

   task automatic send_slots(input logic [15:0] m, input int lo, input int hi, input int skew);
      for (int i = lo; i <= hi; i++) begin
         send_slot(m[i], (i == 0), skew);
      end
   endtask

   task automatic send_frame(input logic [15:0] m, input int skew);
      send_slots(m, 0, 15, skew);
   endtask

   initial begin
      repeat (3) @(posedge mCLK);
      #3;
      chk("rst_mask", 32'(oMASK), 32'h0);
      chk("rst_valid", 32'(oVALID), 32'h0);
      chk("rst_locked", 32'(oLOCKED), 32'h0);
      chk("rst_err", 32'(oERR), 32'h0);
      nRST = 1'b1;
      repeat (2) @(posedge mCLK);
      #3;

      // Basic recovery and lock
      send_frame(16'h3445, 0);
      chk("f1_valid_cnt", 32'(valid_cnt), 32'd1);
      chk("f1_mask", 32'(oMASK), 32'h3445);
      chk("f1_locked", 32'(oLOCKED), 32'h0);
      send_frame(16'h3445, 0);
      chk("f2_valid_cnt", 32'(valid_cnt), 32'd2);
      chk("f2_locked", 32'(oLOCKED), 32'h1);
      chk("f2_err_cnt", 32'(err_cnt), 32'd0);

      // Mask change while locked
      send_frame(16'hFFFE, 0);
      chk("chg_err_cnt", 32'(err_cnt), 32'd1);
      chk("chg_both_cnt", 32'(both_cnt), 32'd1);
      chk("chg_mask", 32'(oMASK), 32'hFFFE);
      chk("chg_locked", 32'(oLOCKED), 32'h0);
      send_frame(16'hFFFE, 0);
      chk("chg_relock", 32'(oLOCKED), 32'h1);
      chk("chg_err_hold", 32'(err_cnt), 32'd1);
      send_frame(16'h3445, 0);
      send_frame(16'h3445, 0);
      chk("back_locked", 32'(oLOCKED), 32'h1);

      // Early marker at slot 7
      v0 = valid_cnt; e0 = err_cnt;
      send_slots(16'h3445, 0, 6, 0);
      send_slots(16'h3445, 0, 0, 0);
      chk("early_err", 32'(err_cnt - e0), 32'd1);
      chk("early_no_valid", 32'(valid_cnt - v0), 32'd0);
      chk("early_locked", 32'(oLOCKED), 32'h0);
      send_slots(16'h3445, 1, 15, 0);
      chk("early_frame_valid", 32'(valid_cnt - v0), 32'd1);
      chk("early_frame_mask", 32'(oMASK), 32'h3445);
      chk("early_frame_locked", 32'(oLOCKED), 32'h0);
      send_frame(16'h3445, 0);
      chk("early_relock", 32'(oLOCKED), 32'h1);

      // Asynchronous reset mid-frame
      send_slots(16'h3445, 0, 4, 0);
      @(posedge mCLK);
      #1;
      nRST = 1'b0;
      #1;
      chk("arst_mask", 32'(oMASK), 32'h0);
      chk("arst_locked", 32'(oLOCKED), 32'h0);
      chk("arst_valid", 32'(oVALID), 32'h0);
      chk("arst_err", 32'(oERR), 32'h0);
      #21;
      nRST = 1'b1;
      @(posedge mCLK);
      #3;
      v0 = valid_cnt; e0 = err_cnt;
      send_slots(16'h3445, 5, 15, 0);
      chk("hunt_ignore_valid", 32'(valid_cnt - v0), 32'd0);
      chk("hunt_ignore_err", 32'(err_cnt - e0), 32'd0);
      send_frame(16'h3445, 0);
      chk("arst_f1_mask", 32'(oMASK), 32'h3445);
      chk("arst_f1_locked", 32'(oLOCKED), 32'h0);
      send_frame(16'h3445, 0);
      chk("arst_f2_locked", 32'(oLOCKED), 32'h1);

      // All-passed and all-skipped masks with iSCLK skew
      send_frame(16'h0000, 0);
      chk("zero_mask", 32'(oMASK), 32'h0000);
      e0 = err_cnt;
      send_frame(16'h0000, 1);
      send_frame(16'h0000, 2);
      chk("zero_skew_err", 32'(err_cnt - e0), 32'd0);
      chk("zero_skew_mask", 32'(oMASK), 32'h0000);
      chk("zero_skew_locked", 32'(oLOCKED), 32'h1);
      send_frame(16'hFFFF, 2);
      chk("ones_mask", 32'(oMASK), 32'hFFFF);
      e0 = err_cnt;
      send_frame(16'hFFFF, 1);
      chk("ones_locked", 32'(oLOCKED), 32'h1);
      chk("ones_err", 32'(err_cnt - e0), 32'd0);

      // Enable dropped for 3 slots while locked
      v0 = valid_cnt; e0 = err_cnt; b0 = both_cnt;
      send_slots(16'hFFFF, 0, 5, 0);
      E = 1'b0;
      send_slots(16'hFFFF, 6, 8, 0);
      chk("en_locked", 32'(oLOCKED), 32'h0);
      chk("en_mask_hold", 32'(oMASK), 32'hFFFF);
      E = 1'b1;
      send_slots(16'hFFFF, 9, 15, 0);
      chk("en_no_valid", 32'(valid_cnt - v0), 32'd0);
      send_frame(16'hFFFF, 0);
      chk("en_f1_locked", 32'(oLOCKED), 32'h0);
      chk("en_f1_valid", 32'(valid_cnt - v0), 32'd1);
      send_frame(16'hFFFF, 0);
      chk("en_f2_locked", 32'(oLOCKED), 32'h1);
      chk("en_no_err", 32'(err_cnt - e0), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
